// File: rtl/fpu_pkg.sv
// Shared floating-point definitions for the ISS FPU (divider and multiplier).
//   state_t  : sequencing states of the iterative divider
//   fclass_t : operand class flags (zero / inf / nan / snan)
//   fflags_t : IEEE-754 exception flag set (NV, DZ, OF, UF, NX)
//   classify : decodes a single-precision operand into fclass_t
package fpu_pkg;

    typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
    localparam int unsigned BIAS      = 127;
    localparam int unsigned QBITS     = 26;

    typedef struct packed {
        logic zero;
        logic inf;
        logic nan;
        logic snan;
    } fclass_t;

    typedef struct packed {
        logic invalid;
        logic div_zero;
        logic overflow;
        logic underflow;
        logic inexact;
    } fflags_t;

    // Subnormals count as zero: the FPU flushes them on input.
    function automatic fclass_t classify(input logic [31:0] x);
        fclass_t c;
        c.zero = (x[30:23] == 8'h00);
        c.inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
        c.nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
        c.snan = c.nan && !x[22];
        return c;
    endfunction

endpackage

// File: rtl/fdiv_round.sv
// Combinational back end of the divider: normalize the raw quotient, round to
// nearest-even, range check and pack.
//   sign   : result sign
//   exp    : biased result exponent before normalization (signed)
//   q      : raw quotient bits, ratio in [0.5, 2) with q[QBITS-1] weighing 1
//   rem_nz : final partial remainder was nonzero
//   out    : packed single-precision result
//   flags  : overflow / underflow / inexact (invalid and div_zero stay 0)
module fdiv_round import fpu_pkg::*; #(
    parameter int unsigned F_WIDTH = 32,
    parameter int unsigned F_EXP   = 8,
    parameter int unsigned F_FLAC  = 23
) (
    input  logic                     sign,
    input  logic signed [F_EXP+1:0]  exp,
    input  logic [QBITS-1:0]         q,
    input  logic                     rem_nz,
    output logic [F_WIDTH-1:0]       out,
    output fflags_t                  flags
);

    localparam int unsigned EW = F_EXP + 2;
    localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << F_EXP) - 1);

    logic [F_FLAC:0]          sig;
    logic [F_FLAC-1:0]        frac;
    logic                     guard;
    logic                     sticky;
    logic                     inc;
    logic signed [EW-1:0]     exp_n;
    logic signed [EW-1:0]     exp_r;

    always_comb begin
        if (q[QBITS-1]) begin
            sig    = q[QBITS-1:2];
            guard  = q[1];
            sticky = q[0] | rem_nz;
            exp_n  = exp;
        end else begin
            sig    = q[QBITS-2:1];
            guard  = q[0];
            sticky = rem_nz;
            exp_n  = exp - EW'(1);
        end

        inc = guard & (sticky | sig[0]);
        // An all-ones significand rounding up wraps the fraction to zero,
        // which is exactly 1.0 at the next exponent.
        frac  = sig[F_FLAC-1:0] + {{(F_FLAC-1){1'b0}}, inc};
        exp_r = (inc && (&sig)) ? exp_n + EW'(1) : exp_n;

        flags         = '0;
        flags.inexact = guard | sticky;
        if (exp_r >= EXP_MAX) begin
            out            = {sign, {F_EXP{1'b1}}, {F_FLAC{1'b0}}};
            flags.overflow = 1'b1;
            flags.inexact  = 1'b1;
        end else if (exp_r <= EW'(0)) begin
            out             = {sign, {(F_WIDTH-1){1'b0}}};
            flags.underflow = 1'b1;
            flags.inexact   = 1'b1;
        end else begin
            out = {sign, exp_r[F_EXP-1:0], frac};
        end
    end

endmodule

// File: rtl/fdiv_seq.sv
// Iterative single-precision divider (in1 / in2), radix-2 restoring, one
// quotient bit per clock, round-to-nearest-even, flush-to-zero.
//   CLK, RST              : clock, asynchronous active-high reset
//   req_valid / req_ready : operand handshake (accepted only in IDLE)
//   in1, in2              : dividend, divisor
//   resp_valid/resp_ready : result handshake
//   out                   : quotient
//   invalid, div_zero, overflow, underflow, inexact : exception flags
module fdiv_seq import fpu_pkg::*; #(
    parameter int unsigned F_WIDTH = 32,
    parameter int unsigned F_EXP   = 8,
    parameter int unsigned F_FLAC  = 23
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [F_WIDTH-1:0] in1,
    input  logic [F_WIDTH-1:0] in2,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [F_WIDTH-1:0] out,
    output logic               invalid,
    output logic               div_zero,
    output logic               overflow,
    output logic               underflow,
    output logic               inexact
);

    localparam int unsigned MW = F_FLAC + 1;
    localparam int unsigned EW = F_EXP + 2;

    state_t                state_q, state_d;
    logic [4:0]            cnt_q, cnt_d;
    logic [MW:0]           rem_q, rem_d;
    logic [MW-1:0]         divisor_q, divisor_d;
    logic [QBITS-1:0]      quo_q, quo_d;
    logic                  sign_q, sign_d;
    logic signed [EW-1:0]  exp_q, exp_d;
    logic [F_WIDTH-1:0]    out_q, out_d;
    fflags_t               flags_q, flags_d;
    logic                  resp_valid_q, resp_valid_d;

    fclass_t               cls1, cls2;
    logic                  sgn;
    logic [F_WIDTH-1:0]    inf_val, zero_val;
    logic [MW+1:0]         trial;
    logic                  qbit;
    logic [MW:0]           rem_next;
    logic [F_WIDTH-1:0]    rnd_out;
    fflags_t               rnd_flags;

    assign cls1     = classify(in1);
    assign cls2     = classify(in2);
    assign sgn      = in1[F_WIDTH-1] ^ in2[F_WIDTH-1];
    assign inf_val  = {sgn, {F_EXP{1'b1}}, {F_FLAC{1'b0}}};
    assign zero_val = {sgn, {(F_WIDTH-1){1'b0}}};

    // Remainder stays below twice the divisor, so MW+1 bits hold it and the
    // selected remainder always fits in MW bits before the shift.
    assign trial    = {1'b0, rem_q} - {2'b00, divisor_q};
    assign qbit     = ~trial[MW+1];
    assign rem_next = qbit ? trial[MW:0] : rem_q;

    fdiv_round #(
        .F_WIDTH (F_WIDTH),
        .F_EXP   (F_EXP),
        .F_FLAC  (F_FLAC)
    ) u_round (
        .sign   (sign_q),
        .exp    (exp_q),
        .q      (quo_q),
        .rem_nz (|rem_q),
        .out    (rnd_out),
        .flags  (rnd_flags)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rem_d        = rem_q;
        divisor_d    = divisor_q;
        quo_d        = quo_q;
        sign_d       = sign_q;
        exp_d        = exp_q;
        out_d        = out_q;
        flags_d      = flags_q;
        resp_valid_d = resp_valid_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    sign_d  = sgn;
                    flags_d = '0;
                    state_d = DONE;
                    if (cls1.nan || cls2.nan) begin
                        out_d           = CANON_NAN;
                        flags_d.invalid = cls1.snan | cls2.snan;
                    end else if ((cls1.zero && cls2.zero) || (cls1.inf && cls2.inf)) begin
                        out_d           = CANON_NAN;
                        flags_d.invalid = 1'b1;
                    end else if (cls1.inf) begin
                        out_d = inf_val;
                    end else if (cls2.zero) begin
                        out_d            = inf_val;
                        flags_d.div_zero = 1'b1;
                    end else if (cls1.zero || cls2.inf) begin
                        out_d = zero_val;
                    end else begin
                        state_d   = DIV;
                        cnt_d     = 5'(QBITS - 1);
                        rem_d     = {1'b0, 1'b1, in1[F_FLAC-1:0]};
                        divisor_d = {1'b1, in2[F_FLAC-1:0]};
                        quo_d     = '0;
                        exp_d     = $signed({2'b00, in1[F_WIDTH-2 -: F_EXP]})
                                  - $signed({2'b00, in2[F_WIDTH-2 -: F_EXP]})
                                  + $signed(EW'(BIAS));
                    end
                end
            end
            DIV: begin
                rem_d = rem_next << 1;
                quo_d = {quo_q[QBITS-2:0], qbit};
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                out_d   = rnd_out;
                flags_d = rnd_flags;
                state_d = DONE;
            end
            DONE: begin
                // Result registers settle for a cycle before resp_valid rises,
                // so resp_valid is a plain flop with no path from any input.
                if (!resp_valid_q) begin
                    resp_valid_d = 1'b1;
                end else if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rem_q        <= '0;
            divisor_q    <= '0;
            quo_q        <= '0;
            sign_q       <= 1'b0;
            exp_q        <= '0;
            out_q        <= '0;
            flags_q      <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rem_q        <= rem_d;
            divisor_q    <= divisor_d;
            quo_q        <= quo_d;
            sign_q       <= sign_d;
            exp_q        <= exp_d;
            out_q        <= out_d;
            flags_q      <= flags_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign out        = out_q;
    assign invalid    = flags_q.invalid;
    assign div_zero   = flags_q.div_zero;
    assign overflow   = flags_q.overflow;
    assign underflow  = flags_q.underflow;
    assign inexact    = flags_q.inexact;

endmodule

// File: tb/tb_fdiv_seq.sv
// Self-checking bench for fdiv_seq: directed cases, reset abort, and randomized
// operands checked against an arithmetic reference model.
module tb_fdiv_seq;

    logic        CLK = 1'b0;
    logic        RST;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] out;
    logic        invalid, div_zero, overflow, underflow, inexact;
    logic [4:0]  dut_flags;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    assign dut_flags = {invalid, div_zero, overflow, underflow, inexact};

    fdiv_seq dut (
        .CLK        (CLK),
        .RST        (RST),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .in1        (in1),
        .in2        (in2),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .out        (out),
        .invalid    (invalid),
        .div_zero   (div_zero),
        .overflow   (overflow),
        .underflow  (underflow),
        .inexact    (inexact)
    );

    initial forever #5 CLK = ~CLK;
    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, need %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Reference: {out[31:0], invalid, div_zero, overflow, underflow, inexact}
    function automatic logic [36:0] model(input logic [31:0] a, input logic [31:0] b);
        logic s, z1, z2, i1, i2, n1, n2, sn1, sn2, nx;
        int e1, e2, e, sh;
        longint unsigned num, den, q, r, sig, lower, half;
        s   = a[31] ^ b[31];
        e1  = int'(a[30:23]);
        e2  = int'(b[30:23]);
        z1  = (e1 == 0);
        z2  = (e2 == 0);
        i1  = (e1 == 255) && (a[22:0] == 0);
        i2  = (e2 == 255) && (b[22:0] == 0);
        n1  = (e1 == 255) && (a[22:0] != 0);
        n2  = (e2 == 255) && (b[22:0] != 0);
        sn1 = n1 && !a[22];
        sn2 = n2 && !b[22];
        if (n1 || n2) return {32'h7FC00000, sn1 | sn2, 4'b0000};
        if ((z1 && z2) || (i1 && i2)) return {32'h7FC00000, 5'b10000};
        if (i1) return {s, 8'hFF, 23'd0, 5'b00000};
        if (z2) return {s, 8'hFF, 23'd0, 5'b01000};
        if (z1 || i2) return {s, 31'd0, 5'b00000};
        num = {40'd0, 1'b1, a[22:0]};
        num = num << 25;
        den = {40'd0, 1'b1, b[22:0]};
        q   = num / den;
        r   = num % den;
        e   = e1 - e2 + 127;
        if (q >= 64'd33554432) sh = 2;
        else begin
            sh = 1;
            e  = e - 1;
        end
        half  = 64'd1 << (sh - 1);
        lower = q % (64'd1 << sh);
        sig   = q >> sh;
        if (lower > half || (lower == half && (r != 0 || sig[0]))) sig = sig + 1;
        if (sig == 64'd16777216) begin
            sig = 64'd8388608;
            e   = e + 1;
        end
        nx = (lower != 0) || (r != 0);
        if (e >= 255) return {s, 8'hFF, 23'd0, 5'b00101};
        if (e <= 0) return {s, 31'd0, 5'b00011};
        return {s, e[7:0], sig[22:0], 4'b0000, nx};
    endfunction

    function automatic logic is_special(input logic [31:0] a, input logic [31:0] b);
        return (a[30:23] == 8'h00) || (a[30:23] == 8'hFF) ||
               (b[30:23] == 8'h00) || (b[30:23] == 8'hFF);
    endfunction

    function automatic logic [31:0] rand_op();
        logic s;
        int   k;
        s = 1'($urandom);
        k = int'($urandom_range(0, 11));
        case (k)
            0:       return {s, 8'h00, 23'($urandom) & {23{1'($urandom)}}};
            1:       return {s, 8'hFF, 23'd0};
            2:       return {s, 8'hFF, 1'b1, 22'($urandom)};
            3:       return {s, 8'hFF, 1'b0, 22'($urandom) | 22'd1};
            4:       return {s, 8'($urandom_range(1, 254)), 23'h7FFFFF};
            5:       return {s, 8'($urandom_range(1, 254)), 23'd0};
            6:       return {s, 8'($urandom_range(100, 154)), 23'($urandom)};
            default: return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
        endcase
    endfunction

    // Scoreboard: every cycle outside reset, handshake and result against model.
    logic [36:0] exp_q[$];
    int          due_q[$];
    logic        seen = 1'b0;

    initial forever begin
        @(negedge CLK);
        if (RST) begin
            exp_q.delete();
            due_q.delete();
            seen = 1'b0;
            chk("rst_req_ready", req_ready, 1);
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_out_flags", {out, dut_flags}, 0);
        end else begin
            chk("mon_req_ready", req_ready, exp_q.size() == 0);
            if (exp_q.size() == 0) begin
                chk("mon_idle_valid", resp_valid, 0);
            end else begin
                if (!seen) chk("mon_valid_timing", resp_valid, cyc >= due_q[0]);
                if (resp_valid) begin
                    seen = 1'b1;
                    chk("mon_result", {out, dut_flags}, exp_q[0]);
                    if (resp_ready) begin
                        void'(exp_q.pop_front());
                        void'(due_q.pop_front());
                        seen = 1'b0;
                    end
                end
            end
            if (req_valid && req_ready) begin
                exp_q.push_back(model(in1, in2));
                due_q.push_back(cyc + 1 + (is_special(in1, in2) ? 1 : 28));
            end
        end
    end

    // Called and returns at #1 after a rising edge.
    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [36:0] want, input int want_lat, input int hold);
        int          t;
        int          lat;
        logic [31:0] o;
        logic [4:0]  f;
        t = 0;
        while (!req_ready && t < 100) begin
            @(posedge CLK); #1;
            t++;
        end
        chk({name, "_req_ready"}, req_ready, 1);
        in1       = a;
        in2       = b;
        req_valid = 1'b1;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        in1       = $urandom;
        in2       = $urandom;
        lat       = 0;
        while (!resp_valid && lat < 60) begin
            @(posedge CLK); #1;
            lat++;
        end
        chk({name, "_latency"}, lat, want_lat);
        chk({name, "_result"}, {out, dut_flags}, want);
        o = out;
        f = dut_flags;
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK); #1;
            chk({name, "_hold"}, {resp_valid, req_ready, out, f}, {1'b1, 1'b0, o, dut_flags});
        end
        resp_ready = 1'b1;
        @(posedge CLK); #1;
        resp_ready = 1'b0;
        chk({name, "_released"}, {req_ready, resp_valid}, 2'b10);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a, b;
        int          nv;
        RST        = 1'b1;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        in1        = '0;
        in2        = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_state", {req_ready, resp_valid, out, dut_flags}, {2'b10, 37'd0});
        RST = 1'b0;

        chk("model_6_2", model(32'h40C00000, 32'h40000000), {32'h40400000, 5'b00000});
        chk("model_1_3", model(32'h3F800000, 32'h40400000), {32'h3EAAAAAB, 5'b00001});
        chk("model_1_0", model(32'h3F800000, 32'h00000000), {32'h7F800000, 5'b01000});
        chk("model_snan", model(32'h7F800001, 32'h3F800000), {32'h7FC00000, 5'b10000});
        chk("model_ovf", model(32'h7F7FFFFF, 32'h00800000), {32'h7F800000, 5'b00101});
        chk("model_unf", model(32'h00800000, 32'h7F7FFFFF), {32'h00000000, 5'b00011});

        @(posedge CLK); #1;
        run_op("div_6_2", 32'h40C00000, 32'h40000000, {32'h40400000, 5'b00000}, 28, 5);
        run_op("div_1_3", 32'h3F800000, 32'h40400000, {32'h3EAAAAAB, 5'b00001}, 28, 0);
        run_op("div_1_0", 32'h3F800000, 32'h00000000, {32'h7F800000, 5'b01000}, 1, 0);
        run_op("div_0_n0", 32'h00000000, 32'h80000000, {32'h7FC00000, 5'b10000}, 1, 2);
        run_op("div_snan", 32'h7F800001, 32'h3F800000, {32'h7FC00000, 5'b10000}, 1, 0);
        run_op("div_qnan0", 32'h7FC00001, 32'h00000000, {32'h7FC00000, 5'b00000}, 1, 0);
        run_op("div_ninf", 32'hFF800000, 32'h3F800000, {32'hFF800000, 5'b00000}, 1, 0);
        run_op("div_x_inf", 32'hC0000000, 32'h7F800000, {32'h80000000, 5'b00000}, 1, 0);
        run_op("div_ovf", 32'h7F7FFFFF, 32'h00800000, {32'h7F800000, 5'b00101}, 28, 1);
        run_op("div_unf", 32'h00800000, 32'h7F7FFFFF, {32'h00000000, 5'b00011}, 28, 0);

        // Abort in the middle of the iteration.
        in1       = 32'h40C00000;
        in2       = 32'h40000000;
        req_valid = 1'b1;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        repeat (10) @(posedge CLK);
        #1;
        RST = 1'b1;
        #1;
        chk("abort_now", {resp_valid, req_ready, out, dut_flags}, {2'b01, 37'd0});
        @(posedge CLK); #1;
        RST = 1'b0;
        nv  = 0;
        repeat (40) begin
            @(posedge CLK); #1;
            if (resp_valid) nv++;
        end
        chk("abort_no_stale", nv, 0);
        run_op("after_abort", 32'h40C00000, 32'h40000000, {32'h40400000, 5'b00000}, 28, 0);

        for (int i = 0; i < 150; i++) begin
            a = rand_op();
            b = rand_op();
            run_op("rand", a, b, model(a, b), is_special(a, b) ? 1 : 28,
                   int'($urandom_range(0, 3)));
        end

        repeat (3) @(posedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fdiv_seq.md
Name: fdiv_seq

Overview:
Iterative single-precision IEEE-754 divider (in1 / in2) for the ISS floating-point unit. It is the inverse operation of the combinational multiplier.
- Radix-2 restoring division, one quotient bit per clock.
- Round-to-nearest-even.
- Valid/ready handshake on both request and response, so the core can stall on FDIV.S while other units proceed.

Parameters:
- F_WIDTH, 32, total float width (only 32 supported).
- F_EXP, 8, exponent field width.
- F_FLAC, 23, fraction field width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- req_valid  in  1  operands valid.
- req_ready  out  1  divider can accept a request.
- in1  in  F_WIDTH  dividend.
- in2  in  F_WIDTH  divisor.
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts result.
- out  out  F_WIDTH  quotient.
- invalid  out  1  NV flag.
- div_zero  out  1  DZ flag.
- overflow  out  1  OF flag.
- underflow  out  1  UF flag.
- inexact  out  1  NX flag.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, req_ready=1, resp_valid=0.
  - out=0, all flags=0.
  - Reset mid-operation aborts; no response is produced for the aborted request.
- States:
  - IDLE: req_ready=1. Accept when req_valid&req_ready; latch sign, exponents and mantissas. Special case goes to DONE; otherwise goes to DIV.
  - DIV: 26 cycles, counter 25..0. Each cycle: trial = rem - divisor; if trial ≥ 0 then rem=trial, qbit=1, else qbit=0; rem <<= 1.
  - ROUND: one cycle. Normalize, round, pack, set flags. Then go to DONE.
  - DONE: resp_valid=1; out and flags held stable. On resp_ready go to IDLE; req_ready returns the following cycle.
- Latency, with the accept edge = cycle 0:
  - resp_valid=1 after edge 28 for normal operands.
  - resp_valid=1 after edge 1 for special cases.
  - resp_valid never combinationally depends on resp_ready.
- Operand classes:
  - Exponent 0 is zero: subnormal inputs are flushed to signed zero.
  - Exponent 255 with frac≠0 is NaN; sNaN when frac[22]=0.
  - Exponent 255 with frac=0 is inf.
- Special cases, in priority order:
  - Any NaN: out=0x7FC00000; invalid=1 iff either operand is sNaN.
  - 0/0 or inf/inf: out=0x7FC00000, invalid=1.
  - inf/x: out=signed inf, no flags.
  - x/0 (x finite, nonzero): out=signed inf, div_zero=1.
  - 0/x or x/inf: out=signed zero, no flags.
- Arithmetic for normal operands:
  - sign = s1^s2.
  - exp = e1 - e2 + 127, 10-bit signed.
  - Mantissas are {1,frac}; the initial remainder is the dividend mantissa.
  - The 26 quotient bits q[25:0] represent the ratio in [0.5, 2).
  - If q[25]=1: sig=q[25:2], guard=q[1], sticky=q[0]|(rem≠0).
  - Else: sig=q[24:1], guard=q[0], sticky=(rem≠0), exp -= 1.
- Rounding (RNE):
  - Increment when guard & (sticky | sig[0]).
  - Carry out of sig sets sig=0x800000 and exp += 1.
  - inexact = guard|sticky.
- Range:
  - exp ≥ 255: out=signed inf, overflow=1, inexact=1.
  - exp ≤ 0: out=signed zero, underflow=1, inexact=1 (subnormal results are flushed).
  - Otherwise: out={sign, exp[7:0], sig[22:0]}.
- Handshake:
  - req_valid is ignored outside IDLE.
  - Inputs may change freely after the accept edge.
  - A back-to-back request is accepted at the earliest one cycle after the resp handshake.

Decomposition:
- Package fpu_pkg holds:
  - state enum {IDLE, DIV, ROUND, DONE};
  - CANON_NAN=32'h7FC00000;
  - BIAS=127 and QBITS=26;
  - a typedef struct for operand class flags (zero/inf/nan/snan), shared with the multiplier.
- One sub-module, fdiv_round: combinational normalize, RNE round, range check and pack. Inputs are sign, exp, q, rem≠0; outputs are out and the flag set.

Test Plan:
- 0x40C00000 / 0x40000000 (6/2) -> out=0x40400000, all flags 0, resp_valid exactly 28 cycles after accept.
- 0x3F800000 / 0x40400000 (1/3) -> out=0x3EAAAAAB, inexact=1, other flags 0.
- 0x3F800000 / 0x00000000 -> out=0x7F800000, div_zero=1, resp_valid 1 cycle after accept.
- 0x00000000 / 0x80000000 -> out=0x7FC00000, invalid=1. Also 0x7F800001 / 0x3F800000 -> 0x7FC00000, invalid=1.
- 0x7F7FFFFF / 0x00800000 -> out=0x7F800000, overflow=1, inexact=1. 0x00800000 / 0x7F7FFFFF -> out=0x00000000, underflow=1, inexact=1.
- Hold resp_ready=0 for 5 cycles after resp_valid -> out and flags stable, req_ready=0. Separately, assert RST at DIV iteration 10 -> resp_valid=0 and req_ready=1 immediately, and no stale response afterwards.
